// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and helpers for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_GNT,
        ST_WAIT_RESP
    } arb_state_t;

    typedef enum logic {
        OWNER_D,
        OWNER_I
    } arb_owner_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// rtl/mem_port_arbiter_sat_counter.sv - saturating counter with increment, clear and hold
module mem_port_arbiter_sat_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = cnt_width(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data access
// Data has priority; a starvation counter forces a pending fetch through after STARVE_MAX losses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_flush,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic                bus_gnt,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int CNT_W = cnt_width(STARVE_MAX);
    localparam int BE_W  = DATA_W / 8;

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic              drop_q, drop_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [BE_W-1:0]   bus_be_q, bus_be_d;

    logic [CNT_W-1:0]  starve_cnt;
    logic              starve_inc;
    logic              starve_clr;
    logic              fetch_ok;
    logic              fetch_forced;

    mem_port_arbiter_sat_counter #(
        .MAX (STARVE_MAX),
        .W   (CNT_W)
    ) u_starve_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc_i (starve_inc),
        .clr_i (starve_clr),
        .cnt_o (starve_cnt)
    );

    // A fetch being redirected this cycle does not take part in arbitration.
    assign fetch_ok     = i_req && !i_flush;
    assign fetch_forced = fetch_ok && (starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        drop_d      = drop_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        starve_inc  = 1'b0;
        starve_clr  = 1'b0;
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;
        i_rvalid    = 1'b0;
        d_rvalid    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (d_req && !fetch_forced) begin
                    owner_d     = OWNER_D;
                    bus_we_d    = d_we;
                    bus_addr_d  = d_addr;
                    bus_wdata_d = d_wdata;
                    bus_be_d    = d_be;
                    bus_req_d   = 1'b1;
                    drop_d      = 1'b0;
                    state_d     = ST_WAIT_GNT;
                    starve_inc  = fetch_ok;
                end else if (fetch_ok) begin
                    owner_d     = OWNER_I;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = i_addr;
                    bus_wdata_d = '0;
                    bus_be_d    = '1;
                    bus_req_d   = 1'b1;
                    drop_d      = 1'b0;
                    state_d     = ST_WAIT_GNT;
                    starve_clr  = 1'b1;
                end
            end
            ST_WAIT_GNT: begin
                if (bus_gnt) begin
                    i_gnt     = (owner_q == OWNER_I);
                    d_gnt     = (owner_q == OWNER_D);
                    bus_req_d = 1'b0;
                    state_d   = ST_WAIT_RESP;
                    if ((owner_q == OWNER_I) && i_flush) begin
                        drop_d = 1'b1;
                    end
                end else if ((owner_q == OWNER_I) && i_flush) begin
                    bus_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT_RESP: begin
                if (bus_rvalid) begin
                    i_rvalid = (owner_q == OWNER_I) && !drop_q && !i_flush;
                    d_rvalid = (owner_q == OWNER_D);
                    drop_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else if ((owner_q == OWNER_I) && i_flush) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                bus_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_D;
            drop_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            drop_q      <= drop_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;
    assign i_rdata   = bus_rdata;
    assign d_rdata   = bus_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int SMAX = 4;

    logic        clk;
    logic        reset;
    logic        i_req, i_flush, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int n_chk;
    int n_fail;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ir; logic [31:0] ia; logic fl;
        logic        dr; logic dw; logic [31:0] da; logic [31:0] dd; logic [3:0] db;
        logic        bg; logic bv; logic [31:0] bd;
        logic        e_req; logic e_we; logic [31:0] e_addr; logic [31:0] e_wdata; logic [3:0] e_be;
        logic        e_ig; logic e_dg; logic e_ir; logic e_dr; logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t v(input logic ir, input logic [31:0] ia, input logic fl,
                               input logic dr, input logic dw, input logic [31:0] da,
                               input logic [31:0] dd, input logic [3:0] db,
                               input logic bg, input logic bv, input logic [31:0] bd,
                               input logic e_req, input logic e_we, input logic [31:0] e_addr,
                               input logic [31:0] e_wdata, input logic [3:0] e_be,
                               input logic e_ig, input logic e_dg, input logic e_ir,
                               input logic e_dr, input logic [31:0] e_rdata);
        vec_t r;
        r.ir = ir; r.ia = ia; r.fl = fl;
        r.dr = dr; r.dw = dw; r.da = da; r.dd = dd; r.db = db;
        r.bg = bg; r.bv = bv; r.bd = bd;
        r.e_req = e_req; r.e_we = e_we; r.e_addr = e_addr; r.e_wdata = e_wdata; r.e_be = e_be;
        r.e_ig = e_ig; r.e_dg = e_dg; r.e_ir = e_ir; r.e_dr = e_dr; r.e_rdata = e_rdata;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag, input logic e_req, input logic e_we,
                               input logic [31:0] e_addr, input logic [31:0] e_wdata,
                               input logic [3:0] e_be, input logic e_ig, input logic e_dg,
                               input logic e_ir, input logic e_dr, input logic [31:0] e_rdata);
        chk({tag, ".bus_req"}, 32'(bus_req), 32'(e_req));
        if (e_req) begin
            chk({tag, ".bus_we"}, 32'(bus_we), 32'(e_we));
            chk({tag, ".bus_addr"}, bus_addr, e_addr);
            chk({tag, ".bus_wdata"}, bus_wdata, e_wdata);
            chk({tag, ".bus_be"}, 32'(bus_be), 32'(e_be));
        end
        chk({tag, ".i_gnt"}, 32'(i_gnt), 32'(e_ig));
        chk({tag, ".d_gnt"}, 32'(d_gnt), 32'(e_dg));
        chk({tag, ".i_rvalid"}, 32'(i_rvalid), 32'(e_ir));
        chk({tag, ".d_rvalid"}, 32'(d_rvalid), 32'(e_dr));
        if (e_ir) chk({tag, ".i_rdata"}, i_rdata, e_rdata);
        if (e_dr) chk({tag, ".d_rdata"}, d_rdata, e_rdata);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".bus_req"}, 32'(bus_req), 32'd0);
        chk({tag, ".bus_we"}, 32'(bus_we), 32'd0);
        chk({tag, ".bus_addr"}, bus_addr, 32'd0);
        chk({tag, ".bus_wdata"}, bus_wdata, 32'd0);
        chk({tag, ".bus_be"}, 32'(bus_be), 32'd0);
        chk({tag, ".gnt"}, 32'({i_gnt, d_gnt}), 32'd0);
        chk({tag, ".rvalid"}, 32'({i_rvalid, d_rvalid}), 32'd0);
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = 0; i_flush = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    // Transaction-level reference: one outstanding transfer and a loss tally.
    bit          m_busy, m_accepted, m_fetch, m_dropped;
    int          m_losses;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;

    task automatic model_reset();
        m_busy = 0; m_accepted = 0; m_fetch = 0; m_dropped = 0; m_losses = 0;
        m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0;
    endtask

    task automatic model_step();
        bit fetch_ok;
        fetch_ok = i_req && !i_flush;
        if (!m_busy) begin
            if (d_req && !(fetch_ok && m_losses == SMAX)) begin
                m_busy = 1; m_accepted = 0; m_fetch = 0; m_dropped = 0;
                m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
                if (fetch_ok && m_losses < SMAX) m_losses++;
            end else if (fetch_ok) begin
                m_busy = 1; m_accepted = 0; m_fetch = 1; m_dropped = 0;
                m_we = 0; m_addr = i_addr; m_wdata = 0; m_be = 4'hF;
                m_losses = 0;
            end
        end else if (!m_accepted) begin
            if (bus_gnt) begin
                m_accepted = 1;
                if (m_fetch && i_flush) m_dropped = 1;
            end else if (m_fetch && i_flush) begin
                m_busy = 0;
            end
        end else begin
            if (bus_rvalid) m_busy = 0;
            else if (m_fetch && i_flush) m_dropped = 1;
        end
    endtask

    vec_t vecs[20];
    logic [7:0] grants[$];
    bit d_pend, i_pend;
    logic e_req, e_ig, e_dg, e_ir, e_dr;

    initial begin
        n_chk = 0;
        n_fail = 0;
        idle_inputs();
        reset = 1;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 0;

        vecs[0]  = v(0,0,0, 1,0,'h100,0,'hF, 0,0,0, 0,0,0,0,0, 0,0,0,0,0);
        vecs[1]  = v(0,0,0, 1,0,'h100,0,'hF, 1,0,0, 1,0,'h100,0,'hF, 0,1,0,0,0);
        vecs[2]  = v(0,0,0, 0,0,0,0,0, 0,1,'hDEADBEEF, 0,0,0,0,0, 0,0,0,1,'hDEADBEEF);
        vecs[3]  = v(0,0,0, 1,1,'h200,'h12345678,'h3, 0,0,0, 0,0,0,0,0, 0,0,0,0,0);
        vecs[4]  = v(0,0,0, 1,1,'h200,'h12345678,'h3, 0,0,0, 1,1,'h200,'h12345678,'h3, 0,0,0,0,0);
        vecs[5]  = v(0,0,0, 1,1,'h200,'h12345678,'h3, 1,0,0, 1,1,'h200,'h12345678,'h3, 0,1,0,0,0);
        vecs[6]  = v(0,0,0, 0,0,0,0,0, 0,1,0, 0,0,0,0,0, 0,0,0,1,0);
        vecs[7]  = v(1,'h400,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0,0);
        vecs[8]  = v(1,'h400,1, 0,0,0,0,0, 0,0,0, 1,0,'h400,0,'hF, 0,0,0,0,0);
        vecs[9]  = v(0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0,0);
        vecs[10] = v(1,'h500,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0,0);
        vecs[11] = v(1,'h500,0, 1,0,'h600,0,'hF, 1,0,0, 1,0,'h500,0,'hF, 1,0,0,0,0);
        vecs[12] = v(0,0,1, 1,0,'h600,0,'hF, 0,0,0, 0,0,0,0,0, 0,0,0,0,0);
        vecs[13] = v(0,0,0, 1,0,'h600,0,'hF, 0,1,'hCAFEF00D, 0,0,0,0,0, 0,0,0,0,0);
        vecs[14] = v(0,0,0, 1,0,'h600,0,'hF, 0,0,0, 0,0,0,0,0, 0,0,0,0,0);
        vecs[15] = v(0,0,0, 1,0,'h600,0,'hF, 1,0,0, 1,0,'h600,0,'hF, 0,1,0,0,0);
        vecs[16] = v(0,0,0, 0,0,0,0,0, 0,1,'h55, 0,0,0,0,0, 0,0,0,1,'h55);
        vecs[17] = v(0,0,0, 0,0,0,0,0, 1,1,'h77, 0,0,0,0,0, 0,0,0,0,0);
        vecs[18] = v(1,'h700,1, 0,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0,0);
        vecs[19] = v(0,0,0, 0,0,0,0,0, 1,0,0, 0,0,0,0,0, 0,0,0,0,0);

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            i_req = vecs[k].ir; i_addr = vecs[k].ia; i_flush = vecs[k].fl;
            d_req = vecs[k].dr; d_we = vecs[k].dw; d_addr = vecs[k].da;
            d_wdata = vecs[k].dd; d_be = vecs[k].db;
            bus_gnt = vecs[k].bg; bus_rvalid = vecs[k].bv; bus_rdata = vecs[k].bd;
            #1;
            compare_all($sformatf("vec%0d", k), vecs[k].e_req, vecs[k].e_we, vecs[k].e_addr,
                        vecs[k].e_wdata, vecs[k].e_be, vecs[k].e_ig, vecs[k].e_dg,
                        vecs[k].e_ir, vecs[k].e_dr, vecs[k].e_rdata);
        end

        // Continuous contention: every fifth grant must go to fetch.
        do_reset();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            i_req = 1; i_addr = 'h1000; d_req = 1; d_addr = 'h2000; d_be = 'hF;
            bus_gnt = 1; bus_rvalid = 1; bus_rdata = c;
            #1;
            if (i_gnt) begin
                grants.push_back("I");
                chk("contend.i_addr", bus_addr, 'h1000);
            end
            if (d_gnt) begin
                grants.push_back("D");
                chk("contend.d_addr", bus_addr, 'h2000);
            end
            chk("contend.i_pulse", 32'(i_gnt && i_rvalid), 0);
            chk("contend.d_pulse", 32'(d_gnt && d_rvalid), 0);
        end
        chk("contend.count", grants.size(), 10);
        for (int g = 0; g < 10 && g < grants.size(); g++) begin
            chk($sformatf("contend.grant%0d", g), 32'(grants[g]), (g % (SMAX + 1) == SMAX) ? 32'("I") : 32'("D"));
        end

        // Reset while waiting for a load response.
        do_reset();
        @(negedge clk);
        d_req = 1; d_addr = 'h300; d_be = 'hF;
        @(negedge clk);
        bus_gnt = 1;
        #1;
        chk("rst.pre_gnt", 32'(d_gnt), 1);
        @(negedge clk);
        d_req = 0; bus_gnt = 0;
        #1;
        reset = 1;
        bus_rvalid = 1;
        #1;
        check_all_zero("rst.mid");
        @(negedge clk);
        reset = 0;
        #1;
        chk("rst.late_d_rvalid", 32'(d_rvalid), 0);
        chk("rst.late_i_rvalid", 32'(i_rvalid), 0);
        @(negedge clk);
        bus_rvalid = 0; d_req = 1; d_addr = 'h340;
        @(negedge clk);
        bus_gnt = 1;
        #1;
        chk("rst.new_gnt", 32'(d_gnt), 1);
        chk("rst.new_addr", bus_addr, 'h340);
        @(negedge clk);
        d_req = 0; bus_gnt = 0; bus_rvalid = 1; bus_rdata = 'hA5A5;
        #1;
        chk("rst.new_rvalid", 32'(d_rvalid), 1);
        chk("rst.new_rdata", d_rdata, 'hA5A5);

        // Randomized traffic against the transaction-level reference.
        do_reset();
        model_reset();
        d_pend = 0;
        i_pend = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1;
                d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom;
                d_wdata = $urandom;
                d_be = 4'($urandom);
            end
            d_req = d_pend;
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1;
                i_addr = $urandom;
            end
            i_req = i_pend;
            i_flush = ($urandom_range(0, 7) == 0);
            bus_gnt = 1'($urandom_range(0, 1));
            bus_rvalid = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
            #1;
            e_req = m_busy && !m_accepted;
            e_ig  = e_req && bus_gnt && m_fetch;
            e_dg  = e_req && bus_gnt && !m_fetch;
            e_ir  = m_busy && m_accepted && bus_rvalid && m_fetch && !m_dropped && !i_flush;
            e_dr  = m_busy && m_accepted && bus_rvalid && !m_fetch;
            compare_all("rand", e_req, m_we, m_addr, m_wdata, m_be, e_ig, e_dg, e_ir, e_dr, bus_rdata);
            if (e_dg) d_pend = 0;
            if (e_ig || i_flush) i_pend = 0;
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
